// File: rtl/gpr_wb_sched_pkg.sv
// Shared widths and register-index constants for the GPR write-side scheduler.
package gpr_wb_sched_pkg;
    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef logic [REG_W-1:0]  reg_t;
    typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/gpr_wb_sched_if.sv
// Bundle of main-pipe, long-latency, decode and GPR write-port signals.
interface gpr_wb_sched_if;
    import gpr_wb_sched_pkg::*;

    logic  main_wr_en;
    reg_t  main_wr_reg;
    data_t main_wr_data;
    logic  issue_valid;
    reg_t  issue_reg;
    logic  issue_ready;
    logic  ld_valid;
    reg_t  ld_reg;
    data_t ld_data;
    logic  ld_ready;
    reg_t  dec_rs;
    reg_t  dec_rt;
    reg_t  dec_rd;
    data_t gpr_rdata1;
    data_t gpr_rdata2;
    data_t src1_data;
    data_t src2_data;
    logic  hazard_stall;
    logic  GPRWr;
    reg_t  write_reg;
    data_t write_data;

    modport master (
        output main_wr_en, main_wr_reg, main_wr_data,
        output issue_valid, issue_reg, ld_valid, ld_reg, ld_data,
        output dec_rs, dec_rt, dec_rd, gpr_rdata1, gpr_rdata2,
        input  issue_ready, ld_ready, src1_data, src2_data, hazard_stall,
        input  GPRWr, write_reg, write_data
    );

    modport slave (
        input  main_wr_en, main_wr_reg, main_wr_data,
        input  issue_valid, issue_reg, ld_valid, ld_reg, ld_data,
        input  dec_rs, dec_rt, dec_rd, gpr_rdata1, gpr_rdata2,
        output issue_ready, ld_ready, src1_data, src2_data, hazard_stall,
        output GPRWr, write_reg, write_data
    );
endinterface

// File: rtl/gpr_scoreboard.sv
// Busy-register scoreboard and outstanding counter for long-latency ops.
// Latency: busy bits update at the next posedge; ready/stall are combinational.
// Backpressure: issue_ready drops when the counter is full or the destination is busy.
module gpr_scoreboard
    import gpr_wb_sched_pkg::*;
#(
    parameter int MAX_OUT = 2,
    parameter int CNT_W   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic issue_valid,
    input  reg_t issue_reg,
    output logic issue_ready,
    input  logic cmpl_fire,
    input  reg_t cmpl_reg,
    input  reg_t dec_rs,
    input  reg_t dec_rt,
    input  reg_t dec_rd,
    output logic hazard_stall
);
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [CNT_W-1:0]    out_cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                issue_fire;

    assign issue_ready  = !rst && (out_cnt < CNT_W'(MAX_OUT)) && !busy[issue_reg];
    assign issue_fire   = issue_valid && issue_ready;
    // A completing register still stalls this cycle; it releases once busy clears.
    assign hazard_stall = !rst && (busy[dec_rs] || busy[dec_rt] || busy[dec_rd]);

    always_comb begin
        busy_nxt = busy;
        if (cmpl_fire) begin
            busy_nxt[cmpl_reg] = 1'b0;
        end
        if (issue_fire && issue_reg != REG_ZERO) begin
            busy_nxt[issue_reg] = 1'b1;
        end
        busy_nxt[0] = 1'b0;

        cnt_nxt = out_cnt;
        if (issue_fire && !cmpl_fire) begin
            cnt_nxt = out_cnt + CNT_W'(1);
        end else if (cmpl_fire && !issue_fire && out_cnt != '0) begin
            cnt_nxt = out_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= '0;
            out_cnt <= '0;
        end else begin
            busy    <= busy_nxt;
            out_cnt <= cnt_nxt;
        end
    end
endmodule

// File: rtl/gpr_wb_sched.sv
// Sole driver of the GPR write port: main pipe beats long-latency results, with decode bypass.
// Latency: write port is combinational; the register updates at the next posedge.
// Backpressure: ld_ready withheld while the main pipe writes; issue gated by the scoreboard.
module gpr_wb_sched
    import gpr_wb_sched_pkg::*;
#(
    parameter int MAX_OUT = 2,
    parameter int CNT_W   = 2
) (
    input logic           clk,
    input logic           rst,
    gpr_wb_sched_if.slave bus
);
    logic main_act;
    logic ld_fire;

    assign main_act     = !rst && bus.main_wr_en && (bus.main_wr_reg != REG_ZERO);
    assign bus.ld_ready = bus.ld_valid && !main_act && !rst;
    assign ld_fire      = bus.ld_valid && bus.ld_ready;

    // A long-latency result to r0 still completes the handshake but is never written.
    always_comb begin
        bus.GPRWr      = 1'b0;
        bus.write_reg  = REG_ZERO;
        bus.write_data = '0;
        if (main_act) begin
            bus.GPRWr      = 1'b1;
            bus.write_reg  = bus.main_wr_reg;
            bus.write_data = bus.main_wr_data;
        end else if (ld_fire && bus.ld_reg != REG_ZERO) begin
            bus.GPRWr      = 1'b1;
            bus.write_reg  = bus.ld_reg;
            bus.write_data = bus.ld_data;
        end
    end

    always_comb begin
        bus.src1_data = bus.gpr_rdata1;
        bus.src2_data = bus.gpr_rdata2;
        if (bus.GPRWr && bus.write_reg == bus.dec_rs && bus.dec_rs != REG_ZERO) begin
            bus.src1_data = bus.write_data;
        end
        if (bus.GPRWr && bus.write_reg == bus.dec_rt && bus.dec_rt != REG_ZERO) begin
            bus.src2_data = bus.write_data;
        end
    end

    gpr_scoreboard #(
        .MAX_OUT (MAX_OUT),
        .CNT_W   (CNT_W)
    ) u_sb (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (bus.issue_valid),
        .issue_reg    (bus.issue_reg),
        .issue_ready  (bus.issue_ready),
        .cmpl_fire    (ld_fire),
        .cmpl_reg     (bus.ld_reg),
        .dec_rs       (bus.dec_rs),
        .dec_rt       (bus.dec_rt),
        .dec_rd       (bus.dec_rd),
        .hazard_stall (bus.hazard_stall)
    );
endmodule

// File: tb/tb_gpr_wb_sched.sv
// Scenario bench for gpr_wb_sched; GPR writes are matched against an expected-write queue.
module tb_gpr_wb_sched;
    import gpr_wb_sched_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gpr_wb_sched_if bus();

    gpr_wb_sched #(.MAX_OUT(2), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        reg_t  r;
        data_t d;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    // Every GPR write seen must be the oldest still expected one.
    always @(negedge clk) begin
        if (bus.GPRWr === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_unexpected: got reg=%0d data=%h, required no write", bus.write_reg, bus.write_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus.write_reg !== e.r || bus.write_data !== e.d) begin
                    n_fail++;
                    $display("FAIL wr_match: got reg=%0d data=%h, required reg=%0d data=%h", bus.write_reg, bus.write_data, e.r, e.d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.main_wr_en   = 1'b0;
        bus.main_wr_reg  = '0;
        bus.main_wr_data = '0;
        bus.issue_valid  = 1'b0;
        bus.issue_reg    = '0;
        bus.ld_valid     = 1'b0;
        bus.ld_reg       = '0;
        bus.ld_data      = '0;
        bus.dec_rs       = '0;
        bus.dec_rt       = '0;
        bus.dec_rd       = '0;
        bus.gpr_rdata1   = 32'h1111_1111;
        bus.gpr_rdata2   = 32'h2222_2222;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        bus.main_wr_en = 1'b1; bus.main_wr_reg = 5'd3; bus.main_wr_data = 32'h33;
        bus.ld_valid = 1'b1; bus.ld_reg = 5'd6; bus.ld_data = 32'h66;
        bus.issue_valid = 1'b1; bus.issue_reg = 5'd1;
        #1;
        n_tests++; if (bus.GPRWr !== 1'b0 || bus.write_reg !== 5'd0 || bus.write_data !== 32'd0) begin
            n_fail++; $display("FAIL rst_port: got wr=%b reg=%0d data=%h, required 0/0/0", bus.GPRWr, bus.write_reg, bus.write_data); end
        n_tests++; if (bus.ld_ready !== 1'b0 || bus.issue_ready !== 1'b0 || bus.hazard_stall !== 1'b0) begin
            n_fail++; $display("FAIL rst_ctl: got ld_rdy=%b iss_rdy=%b stall=%b, required 0/0/0", bus.ld_ready, bus.issue_ready, bus.hazard_stall); end
        tick();
        rst = 1'b0;
        idle();
        bus.dec_rs = 5'd1; bus.dec_rt = 5'd2; bus.dec_rd = 5'd3; bus.issue_reg = 5'd1;
        #1;
        n_tests++; if (bus.GPRWr !== 1'b0 || bus.issue_ready !== 1'b1 || bus.hazard_stall !== 1'b0) begin
            n_fail++; $display("FAIL idle: got wr=%b iss_rdy=%b stall=%b, required 0/1/0", bus.GPRWr, bus.issue_ready, bus.hazard_stall); end
    endtask

    task automatic test_issue_complete();
        tick();
        idle();
        bus.issue_valid = 1'b1; bus.issue_reg = 5'd5;
        #1;
        n_tests++; if (bus.issue_ready !== 1'b1) begin
            n_fail++; $display("FAIL issue5_rdy: got %b, required 1", bus.issue_ready); end
        tick();
        idle();
        bus.dec_rs = 5'd5;
        #1;
        n_tests++; if (bus.hazard_stall !== 1'b1) begin
            n_fail++; $display("FAIL stall5: got %b, required 1", bus.hazard_stall); end
        tick();
        bus.ld_valid = 1'b1; bus.ld_reg = 5'd5; bus.ld_data = 32'hDEAD_BEEF;
        exp_q.push_back('{r: 5'd5, d: 32'hDEAD_BEEF});
        #1;
        n_tests++; if (bus.GPRWr !== 1'b1 || bus.write_reg !== 5'd5 || bus.write_data !== 32'hDEAD_BEEF || bus.ld_ready !== 1'b1) begin
            n_fail++; $display("FAIL ld5_write: got wr=%b reg=%0d data=%h rdy=%b, required 1/5/deadbeef/1", bus.GPRWr, bus.write_reg, bus.write_data, bus.ld_ready); end
        n_tests++; if (bus.hazard_stall !== 1'b1) begin
            n_fail++; $display("FAIL stall5_cmpl: got %b, required 1", bus.hazard_stall); end
        tick();
        idle();
        bus.dec_rs = 5'd5;
        #1;
        n_tests++; if (bus.hazard_stall !== 1'b0) begin
            n_fail++; $display("FAIL stall5_rel: got %b, required 0", bus.hazard_stall); end
    endtask

    task automatic test_arbitration();
        tick();
        idle();
        bus.ld_valid = 1'b1; bus.ld_reg = 5'd7; bus.ld_data = 32'h11;
        bus.main_wr_en = 1'b1; bus.main_wr_reg = 5'd3; bus.main_wr_data = 32'h22;
        exp_q.push_back('{r: 5'd3, d: 32'h22});
        #1;
        n_tests++; if (bus.write_reg !== 5'd3 || bus.write_data !== 32'h22 || bus.ld_ready !== 1'b0) begin
            n_fail++; $display("FAIL arb_main: got reg=%0d data=%h ld_rdy=%b, required 3/22/0", bus.write_reg, bus.write_data, bus.ld_ready); end
        tick();
        bus.main_wr_en = 1'b0;
        exp_q.push_back('{r: 5'd7, d: 32'h11});
        #1;
        n_tests++; if (bus.write_reg !== 5'd7 || bus.write_data !== 32'h11 || bus.ld_ready !== 1'b1) begin
            n_fail++; $display("FAIL arb_ld: got reg=%0d data=%h ld_rdy=%b, required 7/11/1", bus.write_reg, bus.write_data, bus.ld_ready); end
    endtask

    task automatic test_max_out();
        // Counter must still be 0 here: the stray completion above may not underflow it.
        tick(); idle();
        bus.issue_valid = 1'b1; bus.issue_reg = 5'd8;
        #1;
        n_tests++; if (bus.issue_ready !== 1'b1) begin
            n_fail++; $display("FAIL issue8_rdy: got %b, required 1", bus.issue_ready); end
        tick();
        bus.issue_reg = 5'd9;
        #1;
        n_tests++; if (bus.issue_ready !== 1'b1) begin
            n_fail++; $display("FAIL issue9_rdy: got %b, required 1", bus.issue_ready); end
        tick();
        bus.issue_reg = 5'd10;
        #1;
        n_tests++; if (bus.issue_ready !== 1'b0) begin
            n_fail++; $display("FAIL issue10_full: got %b, required 0", bus.issue_ready); end
        tick(); idle();
        bus.ld_valid = 1'b1; bus.ld_reg = 5'd9; bus.ld_data = 32'h99;
        exp_q.push_back('{r: 5'd9, d: 32'h99});
        tick(); idle();
        bus.issue_reg = 5'd8;
        #1;
        n_tests++; if (bus.issue_ready !== 1'b0) begin
            n_fail++; $display("FAIL issue8_busy: got %b, required 0", bus.issue_ready); end
        bus.issue_reg = 5'd10;
        #1;
        n_tests++; if (bus.issue_ready !== 1'b1) begin
            n_fail++; $display("FAIL issue10_free: got %b, required 1", bus.issue_ready); end
        // Issue and completion in one cycle keep the count at 1.
        tick(); idle();
        bus.ld_valid = 1'b1; bus.ld_reg = 5'd8; bus.ld_data = 32'h88;
        bus.issue_valid = 1'b1; bus.issue_reg = 5'd11;
        exp_q.push_back('{r: 5'd8, d: 32'h88});
        tick(); idle();
        bus.dec_rs = 5'd8; bus.dec_rt = 5'd0; bus.dec_rd = 5'd11;
        #1;
        n_tests++; if (bus.hazard_stall !== 1'b1) begin
            n_fail++; $display("FAIL stall11: got %b, required 1", bus.hazard_stall); end
        bus.dec_rd = 5'd0;
        #1;
        n_tests++; if (bus.hazard_stall !== 1'b0) begin
            n_fail++; $display("FAIL stall8_clr: got %b, required 0", bus.hazard_stall); end
        bus.issue_valid = 1'b1; bus.issue_reg = 5'd12;
        #1;
        n_tests++; if (bus.issue_ready !== 1'b1) begin
            n_fail++; $display("FAIL issue12_rdy: got %b, required 1", bus.issue_ready); end
        tick(); idle();
        bus.issue_reg = 5'd13;
        #1;
        n_tests++; if (bus.issue_ready !== 1'b0) begin
            n_fail++; $display("FAIL issue13_full: got %b, required 0", bus.issue_ready); end
        bus.ld_valid = 1'b1; bus.ld_reg = 5'd11; bus.ld_data = 32'hB11;
        exp_q.push_back('{r: 5'd11, d: 32'hB11});
        tick();
        bus.ld_reg = 5'd12; bus.ld_data = 32'hC12;
        exp_q.push_back('{r: 5'd12, d: 32'hC12});
        tick(); idle();
    endtask

    task automatic test_bypass();
        idle();
        bus.main_wr_en = 1'b1; bus.main_wr_reg = 5'd4; bus.main_wr_data = 32'hCAFE_0001;
        bus.dec_rs = 5'd4; bus.dec_rt = 5'd0;
        exp_q.push_back('{r: 5'd4, d: 32'hCAFE_0001});
        #1;
        n_tests++; if (bus.src1_data !== 32'hCAFE_0001 || bus.src2_data !== 32'h2222_2222) begin
            n_fail++; $display("FAIL byp_rs: got %h/%h, required cafe0001/22222222", bus.src1_data, bus.src2_data); end
        tick();
        bus.main_wr_data = 32'h0BAD_0004;
        bus.dec_rs = 5'd5; bus.dec_rt = 5'd4;
        exp_q.push_back('{r: 5'd4, d: 32'h0BAD_0004});
        #1;
        n_tests++; if (bus.src1_data !== 32'h1111_1111 || bus.src2_data !== 32'h0BAD_0004) begin
            n_fail++; $display("FAIL byp_rt: got %h/%h, required 11111111/0bad0004", bus.src1_data, bus.src2_data); end
        tick();
        bus.main_wr_reg = 5'd0; bus.main_wr_data = 32'h55;
        bus.dec_rs = 5'd0; bus.dec_rt = 5'd0;
        #1;
        n_tests++; if (bus.GPRWr !== 1'b0 || bus.src1_data !== 32'h1111_1111 || bus.src2_data !== 32'h2222_2222) begin
            n_fail++; $display("FAIL byp_r0: got wr=%b %h/%h, required 0 11111111/22222222", bus.GPRWr, bus.src1_data, bus.src2_data); end
    endtask

    task automatic test_reset_mid();
        tick(); idle();
        bus.issue_valid = 1'b1; bus.issue_reg = 5'd6;
        tick(); idle();
        bus.dec_rs = 5'd6;
        #1;
        n_tests++; if (bus.hazard_stall !== 1'b1) begin
            n_fail++; $display("FAIL stall6: got %b, required 1", bus.hazard_stall); end
        tick();
        rst = 1'b1;
        bus.ld_valid = 1'b1; bus.ld_reg = 5'd6; bus.ld_data = 32'h66;
        #1;
        n_tests++; if (bus.GPRWr !== 1'b0 || bus.ld_ready !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_port: got wr=%b ld_rdy=%b, required 0/0", bus.GPRWr, bus.ld_ready); end
        tick();
        rst = 1'b0;
        idle();
        bus.dec_rs = 5'd6;
        bus.issue_valid = 1'b1; bus.issue_reg = 5'd20;
        #1;
        n_tests++; if (bus.hazard_stall !== 1'b0 || bus.issue_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_busy: got stall=%b iss_rdy=%b, required 0/1", bus.hazard_stall, bus.issue_ready); end
        tick();
        bus.issue_reg = 5'd21;
        #1;
        n_tests++; if (bus.issue_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_cnt: got %b, required 1", bus.issue_ready); end
        tick();
        bus.issue_reg = 5'd22;
        #1;
        n_tests++; if (bus.issue_ready !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_full: got %b, required 0", bus.issue_ready); end
        tick(); idle();
    endtask

    initial begin
        test_reset();
        test_issue_complete();
        test_arbitration();
        test_max_out();
        test_bypass();
        test_reset_mid();
        tick();
        n_tests++; if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL wr_missing: got %0d writes outstanding, required 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/gpr_wb_sched.md
Name: gpr_wb_sched

Overview:
- Write-side scheduler for the 32x32 GPR file; the only driver of the GPR write port (GPRWr, write_reg, write_data).
- Arbitrates between two result sources: the single-cycle main pipe (ALU/load) and the long-latency mult/div unit, which uses a valid/ready handshake.
- Keeps a busy-register scoreboard for in-flight long-latency ops and drives the decode-stage hazard stall.
- Bypasses same-cycle GPR writes onto the decode operand reads.

Parameters:
- MAX_OUT, 2, maximum outstanding long-latency ops (1..3).
- CNT_W, 2, width of the outstanding-op counter; must hold MAX_OUT.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- main_wr_en  in  1  main pipe write request this cycle; cannot be stalled.
- main_wr_reg  in  5  main pipe destination register.
- main_wr_data  in  32  main pipe result.
- issue_valid  in  1  decode issues a long-latency op this cycle.
- issue_reg  in  5  destination of the issued op.
- issue_ready  out  1  long-latency issue accepted.
- ld_valid  in  1  long-latency result available.
- ld_reg  in  5  long-latency destination register.
- ld_data  in  32  long-latency result.
- ld_ready  out  1  long-latency result written this cycle.
- dec_rs  in  5  decode source register A.
- dec_rt  in  5  decode source register B.
- dec_rd  in  5  decode destination register (0 if none).
- gpr_rdata1  in  32  GPR read_data1 for dec_rs.
- gpr_rdata2  in  32  GPR read_data2 for dec_rt.
- src1_data  out  32  bypassed operand A.
- src2_data  out  32  bypassed operand B.
- hazard_stall  out  1  decode must stall.
- GPRWr  out  1  GPR write enable.
- write_reg  out  5  GPR write register.
- write_data  out  32  GPR write data.

Behaviour:
- All GPR-side outputs are combinational from the current inputs and state. The GPR write lands at the next posedge, so write latency is 0 cycles to the port and 1 cycle to the register.
- Write arbitration:
  - Main pipe wins; a main write is "active" when main_wr_en=1 and main_wr_reg!=0.
  - ld_ready = ld_valid & !active main write & !rst.
  - Port mux: if an active main write → GPRWr=1, write_reg=main_wr_reg, write_data=main_wr_data.
  - Else if ld_valid & ld_ready & ld_reg!=0 → GPRWr=1 with the ld values.
  - Else GPRWr=0, write_reg=0, write_data=0.
- Handshake: ld_valid, ld_reg and ld_data are held stable until ld_ready. A transfer with ld_reg=0 completes and drops the data.
- Scoreboard (busy[31:1], busy[0] tied 0):
  - An issue fires when issue_valid & issue_ready. It sets busy[issue_reg] if issue_reg!=0 and increments out_cnt.
  - A completion fires when ld_valid & ld_ready. It clears busy[ld_reg] and decrements out_cnt.
  - If the same register is set and cleared in one cycle, set wins; out_cnt is unchanged when both fire.
- issue_ready = !rst & (out_cnt < MAX_OUT) & !busy[issue_reg]. This forbids WAW between long ops.
- hazard_stall = busy[dec_rs] | busy[dec_rt] | busy[dec_rd]. A completion in the current cycle does not mask it; the stall releases the next cycle.
- Bypass: src1_data = write_data if GPRWr & write_reg==dec_rs & dec_rs!=0, else gpr_rdata1. src2_data uses the same rule with dec_rt and gpr_rdata2.
- Reset values: busy=0, out_cnt=0. During rst: GPRWr=0, write_reg=0, write_data=0, ld_ready=0, issue_ready=0, hazard_stall=0.
- Reset mid-operation: all pending scoreboard state is discarded. Any ld result presented in the reset cycle is not written.
- Counter invariants: out_cnt never exceeds MAX_OUT and never underflows. A completion with out_cnt=0 is a protocol error; the counter saturates at 0.

Decomposition:
- Shared package holds constants REG_W=5, DATA_W=32, NUM_REGS=32, REG_ZERO=5'd0.
- Natural sub-module: gpr_scoreboard, containing the busy vector, out_cnt, and the issue_ready / hazard_stall logic.
- Arbitration and bypass stay in the top level.

Test Plan:
- Reset then idle → GPRWr=0, issue_ready=1, hazard_stall=0; after rst drops, busy=0.
- issue_valid, issue_reg=5 → next cycle busy[5]=1; dec_rs=5 gives hazard_stall=1. Then ld_valid, ld_reg=5, ld_data=32'hDEADBEEF with no main write → GPRWr=1, write_reg=5, write_data=DEADBEEF, ld_ready=1; next cycle hazard_stall=0.
- ld_valid (reg 7, 32'h11) together with main_wr_en (reg 3, 32'h22) → write_reg=3, write_data=22, ld_ready=0. Next cycle, with no main write, reg 7 is written.
- Two issues (regs 8, 9) with MAX_OUT=2 → third issue (reg 10) sees issue_ready=0. Issue to busy reg 8 → issue_ready=0.
- main write reg 4 = 32'hCAFE0001 with dec_rs=4, dec_rt=0 → src1_data=CAFE0001, src2_data=gpr_rdata2. Main write to reg 0 → GPRWr=0, no bypass.
- busy[6] set, then rst asserted while ld_valid reg 6 is presented → GPRWr=0, ld_ready=0; after reset busy[6]=0 and out_cnt=0.
